mem_bus_ctrl: RTL and testbench

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

---
 rtl/mem_bus_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// Arbitrates an instruction-fetch port and a data port onto one word-wide memory.
// Sub-word writes are read-modify-write; misaligned/out-of-range data accesses complete with d_err.
module mem_bus_ctrl #(
  parameter int NUM_OF_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_address,
  output logic        mem_write_en,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic [1:0]  o_dbg_state
);

  // Handshake: a requester holds req (and its addr/data) high until it sees its
  // one-cycle ack; requests are only sampled while the FSM is in IDLE.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WRITE  = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [31:0] MAX_ADDR = 32'(NUM_OF_BYTES - 4);

  state_t      r_state;
  state_t      w_next;
  logic        r_last_data;
  logic        r_owner_data;
  logic        r_we;
  logic        r_err;
  logic [1:0]  r_size;
  logic [1:0]  r_lane;
  logic [31:0] r_mem_address;
  logic [31:0] r_mem_write_data;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;

  logic        w_grant_data;
  logic        w_d_err;
  logic [31:0] w_d_aligned;
  logic [31:0] w_rd_ext;
  logic [31:0] w_merged;
  logic        w_unused;

  // Fetch addresses are always word-aligned; the low bits carry no meaning.
  assign w_unused     = ^if_addr[1:0];
  assign w_grant_data = d_req & (~if_req | ~r_last_data);
  assign w_d_aligned  = {d_addr[31:2], 2'b00};
  assign w_d_err      = (d_size == 2'b11)
                      | ((d_size == 2'b01) & d_addr[0])
                      | ((d_size == 2'b10) & (d_addr[1:0] != 2'b00))
                      | (w_d_aligned > MAX_ADDR);

  always_comb begin
    w_rd_ext = mem_read_data;
    w_merged = mem_read_data;
    case (r_size)
      2'b00: begin
        w_rd_ext = {24'd0, mem_read_data[{r_lane, 3'b000} +: 8]};
        w_merged[{r_lane, 3'b000} +: 8] = r_mem_write_data[7:0];
      end
      2'b01: begin
        w_rd_ext = {16'd0, mem_read_data[{r_lane[1], 4'b0000} +: 16]};
        w_merged[{r_lane[1], 4'b0000} +: 16] = r_mem_write_data[15:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_data)  w_next = w_d_err ? S_RESP : S_ACCESS;
        else if (if_req)   w_next = S_ACCESS;
      end
      S_ACCESS: w_next = (r_we && (r_size != 2'b10)) ? S_WRITE : S_RESP;
      S_WRITE:  w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_last_data      <= 1'b0;
      r_owner_data     <= 1'b0;
      r_we             <= 1'b0;
      r_err            <= 1'b0;
      r_size           <= 2'b00;
      r_lane           <= 2'b00;
      r_mem_address    <= 32'd0;
      r_mem_write_data <= 32'd0;
      r_if_rdata       <= 32'd0;
      r_d_rdata        <= 32'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_grant_data) begin
            r_owner_data <= 1'b1;
            r_last_data  <= 1'b1;
            r_we         <= d_we;
            r_size       <= d_size;
            r_lane       <= d_addr[1:0];
            r_err        <= w_d_err;
            if (w_d_err) begin
              r_d_rdata <= 32'd0;
            end else begin
              r_mem_address <= w_d_aligned;
              if (d_we) r_mem_write_data <= d_wdata;
            end
          end else if (if_req) begin
            r_owner_data  <= 1'b0;
            r_last_data   <= 1'b0;
            r_we          <= 1'b0;
            r_size        <= 2'b10;
            r_lane        <= 2'b00;
            r_err         <= 1'b0;
            r_mem_address <= {if_addr[31:2], 2'b00};
          end
        end
        S_ACCESS: begin
          if (!r_we) begin
            if (r_owner_data) r_d_rdata  <= w_rd_ext;
            else              r_if_rdata <= w_rd_ext;
          end else if (r_size != 2'b10) begin
            r_mem_write_data <= w_merged;
          end
        end
        default: ;
      endcase
    end
  end

  // Gating with reset keeps an aborted transaction from acking or writing in the reset cycle.
  assign mem_write_en   = ~reset & (((r_state == S_ACCESS) & r_we & (r_size == 2'b10))
                                    | (r_state == S_WRITE));
  assign if_ack         = ~reset & (r_state == S_RESP) & ~r_owner_data;
  assign d_ack          = ~reset & (r_state == S_RESP) & r_owner_data;
  assign d_err          = d_ack & r_err;
  assign mem_address    = r_mem_address;
  assign mem_write_data = r_mem_write_data;
  assign if_rdata       = r_if_rdata;
  assign d_rdata        = r_d_rdata;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: directed cases plus random traffic against a
// transaction-level model of memory contents, arbitration and response data.
module tb_mem_bus_ctrl;
  localparam int NUM_OF_BYTES = 1024;
  localparam int NWORDS = NUM_OF_BYTES / 4;
  localparam int AW = $clog2(NWORDS);

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic        d_err;
  logic [31:0] d_rdata;
  logic [31:0] mem_address;
  logic        mem_write_en;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic [1:0]  o_dbg_state;

  mem_bus_ctrl #(.NUM_OF_BYTES(NUM_OF_BYTES)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem_address(mem_address), .mem_write_en(mem_write_en),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  logic [31:0] mem [NWORDS];
  logic [31:0] model_mem [NWORDS];
  logic        model_last_data;
  logic [31:0] model_if_rdata;
  logic [31:0] model_d_rdata;
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          wr_cnt = 0;
  logic [31:0] last_wa;
  logic [31:0] last_wd;

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] v;
    v = (32'h9E37_79B9 * 32'(i + 1)) ^ 32'(i);
    if (i == 0) v = 32'hE3A0_0000;
    if (i == 1) v = 32'hEB00_0001;
    if (i == 8) v = 32'hE1A0_0000;
    return v;
  endfunction

  // memory: combinational read, write commits at the edge
  assign mem_read_data = mem[mem_address[AW+1:2]];
  initial begin
    for (int i = 0; i < NWORDS; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mem_write_en) mem[mem_address[AW+1:2]] = mem_write_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_write_en) begin
      wr_cnt++;
      last_wa = mem_address;
      last_wd = mem_write_data;
    end
    if (if_ack && d_ack) chk("dual_ack", 32'(d_ack), 32'd0);
    if (reset && mem_write_en) chk("wen_in_reset", 32'(mem_write_en), 32'd0);
  end

  // driver tasks
  task automatic do_fetch(input logic [31:0] addr);
    int lat;
    int w0;
    bit got;
    exp_q.push_back(model_mem[addr[AW+1:2]]);
    model_if_rdata  = model_mem[addr[AW+1:2]];
    model_last_data = 1'b0;
    w0 = wr_cnt; lat = 0; got = 1'b0;
    if_req = 1'b1; if_addr = addr;
    while (!got && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (d_ack) chk("f_stray_dack", 32'(d_ack), 32'd0);
      got = if_ack;
    end
    chk("f_ack_seen", 32'(got), 32'd1);
    chk("f_latency", lat, 2);
    chk("f_rdata", if_rdata, exp_q.pop_front());
    chk("f_d_rdata_hold", d_rdata, model_d_rdata);
    chk("f_writes", wr_cnt - w0, 0);
    if_req = 1'b0;
    @(posedge clk); #1;
    chk("f_ack_width", 32'(if_ack), 32'd0);
  endtask

  task automatic do_data(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata);
    logic        err;
    logic [31:0] word;
    int nb, off, exp_lat, lat, w0, exp_wr;
    bit got;
    err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr % 4 != 0)
          || ((addr - addr % 4) > 32'(NUM_OF_BYTES - 4));
    nb = 1 << size;
    off = int'(addr % 4);
    exp_wr = 0;
    if (err) begin
      exp_lat = 1;
      model_d_rdata = 32'd0;
    end else begin
      word = model_mem[addr / 4];
      if (!we) begin
        exp_lat = 2;
        model_d_rdata = (nb == 4) ? word : ((word >> (8 * off)) & ((32'h1 << (8 * nb)) - 1));
      end else begin
        exp_lat = (nb == 4) ? 2 : 3;
        exp_wr = 1;
        for (int k = 0; k < nb; k++) word[8 * (off + k) +: 8] = wdata[8 * k +: 8];
        model_mem[addr / 4] = word;
      end
    end
    model_last_data = 1'b1;
    exp_q.push_back(model_d_rdata);
    w0 = wr_cnt; lat = 0; got = 1'b0;
    d_req = 1'b1; d_we = we; d_size = size; d_addr = addr; d_wdata = wdata;
    while (!got && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (if_ack) chk("d_stray_ifack", 32'(if_ack), 32'd0);
      got = d_ack;
    end
    chk("d_ack_seen", 32'(got), 32'd1);
    chk("d_latency", lat, exp_lat);
    chk("d_err", 32'(d_err), 32'(err));
    chk("d_rdata", d_rdata, exp_q.pop_front());
    chk("d_if_rdata_hold", if_rdata, model_if_rdata);
    chk("d_writes", wr_cnt - w0, exp_wr);
    if (exp_wr == 1) begin
      chk("d_wr_addr", last_wa, addr - addr % 4);
      chk("d_wr_data", last_wd, model_mem[addr / 4]);
    end
    d_req = 1'b0; d_we = 1'b0;
    @(posedge clk); #1;
    chk("d_ack_width", 32'(d_ack), 32'd0);
    chk("d_err_idle", 32'(d_err), 32'd0);
  endtask

  // both ports held with reads; grants must alternate starting with the port not granted last
  task automatic arb(input logic [31:0] fa, input logic [31:0] da, input int n);
    int acks, cyc, last_cyc;
    for (int k = 0; k < n; k++) exp_q.push_back(32'((!model_last_data) ^ (k % 2 == 1)));
    if_req = 1'b1; if_addr = fa;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = da;
    acks = 0; cyc = 0; last_cyc = 0;
    while (acks < n && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (if_ack || d_ack) begin
        chk("arb_owner", 32'(d_ack), exp_q.pop_front());
        chk("arb_gap", cyc - last_cyc, (acks == 0) ? 2 : 3);
        if (d_ack) chk("arb_d_rdata", d_rdata, model_mem[da / 4]);
        else       chk("arb_if_rdata", if_rdata, model_mem[fa / 4]);
        model_last_data = d_ack;
        acks++;
        last_cyc = cyc;
      end
    end
    chk("arb_count", acks, n);
    while (exp_q.size() > 0) void'(exp_q.pop_front());
    if_req = 1'b0; d_req = 1'b0;
    model_if_rdata = model_mem[fa / 4];
    model_d_rdata  = model_mem[da / 4];
    @(posedge clk); #1;
    chk("arb_quiet", 32'(if_ack | d_ack), 32'd0);
  endtask

  task automatic rst_in_write(input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] tgt;
    tgt = model_mem[addr / 4];
    d_req = 1'b1; d_we = 1'b1; d_size = 2'd0; d_addr = addr; d_wdata = wdata;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rw_wen_before", 32'(mem_write_en), 32'd1);
    reset = 1'b1; d_req = 1'b0; d_we = 1'b0;
    #1;
    chk("rw_wen_in_reset", 32'(mem_write_en), 32'd0);
    chk("rw_no_ack", 32'(d_ack), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_last_data = 1'b0; model_if_rdata = 32'd0; model_d_rdata = 32'd0;
    chk("rw_state_idle", 32'(o_dbg_state), 32'd0);
    chk("rw_ack_after", 32'(d_ack), 32'd0);
    chk("rw_wen_after", 32'(mem_write_en), 32'd0);
    chk("rw_target", mem[addr / 4], tgt);
    chk("rw_d_rdata", d_rdata, 32'd0);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    reset = 1'b1; if_req = 1'b0; if_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_size = 2'd0; d_addr = 32'd0; d_wdata = 32'd0;
    for (int i = 0; i < NWORDS; i++) model_mem[i] = init_word(i);
    model_last_data = 1'b0; model_if_rdata = 32'd0; model_d_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_ack", 32'(if_ack), 32'd0);
    chk("rst_d_ack", 32'(d_ack), 32'd0);
    chk("rst_d_err", 32'(d_err), 32'd0);
    chk("rst_wen", 32'(mem_write_en), 32'd0);
    chk("rst_maddr", mem_address, 32'd0);
    chk("rst_mwdata", mem_write_data, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);

    // fetch held across reset release
    if_req = 1'b1; if_addr = 32'h4;
    @(posedge clk); #1;
    reset = 1'b0;
    do_fetch(32'h4);
    chk("fetch4_const", if_rdata, 32'hEB00_0001);
    do_fetch(32'h7);
    chk("fetch7_aligned", if_rdata, 32'hEB00_0001);

    do_data(1'b0, 2'd0, 32'h3, 32'd0);
    chk("byte_rd_const", d_rdata, 32'h0000_00E3);
    do_data(1'b0, 2'd1, 32'h2, 32'd0);
    chk("half_rd_const", d_rdata, 32'h0000_E3A0);
    do_data(1'b1, 2'd0, 32'h21, 32'h0000_005A);
    chk("byte_wr_data", last_wd, 32'hE1A0_5A00);
    do_data(1'b0, 2'd2, 32'h20, 32'd0);
    chk("word_rd_const", d_rdata, 32'hE1A0_5A00);

    do_data(1'b0, 2'd2, 32'h2, 32'd0);
    do_data(1'b0, 2'd3, 32'h0, 32'd0);
    do_data(1'b1, 2'd2, 32'h400, 32'hDEAD_BEEF);
    do_data(1'b1, 2'd1, 32'h3FE, 32'h0000_1234);
    do_data(1'b1, 2'd2, 32'h3FC, 32'hCAFE_F00D);
    do_data(1'b0, 2'd1, 32'h3FE, 32'd0);

    rst_in_write(32'h41, 32'h0000_00A5);
    arb(32'h4, 32'h20, 4);

    for (int t = 0; t < 120; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_fetch(32'($urandom_range(0, NUM_OF_BYTES - 1)));
      end else begin
        sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        a = 32'($urandom_range(0, NUM_OF_BYTES + 7));
        if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'h1 << sz) - 1);
        do_data(1'($urandom_range(0, 1)), sz, a, $urandom);
      end
      if (t % 40 == 39) arb(32'($urandom_range(0, NUM_OF_BYTES - 1)), 32'($urandom_range(0, NWORDS - 1) * 4), 4);
    end

    for (int i = 0; i < NWORDS; i++) chk("mem_final", mem[i], model_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
